// File: rtl/mul_add_pipe_if.sv
// rtl/mul_add_pipe_if.sv - operand/result handshake bundle for mul_add_pipe
interface mul_add_pipe_if #(
    parameter int W     = 8,
    parameter int ACC_W = 24
);
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         mode;
    logic [W-1:0]       a_in;
    logic [W-1:0]       b_in;
    logic               out_valid;
    logic               out_ready;
    logic [W:0]         s_out;
    logic [2*W-1:0]     p_out;
    logic [ACC_W-1:0]   acc_out;
    logic [1:0]         out_mode;

    modport master (
        output in_valid, mode, a_in, b_in, out_ready,
        input  in_ready, out_valid, s_out, p_out, acc_out, out_mode
    );

    modport slave (
        input  in_valid, mode, a_in, b_in, out_ready,
        output in_ready, out_valid, s_out, p_out, acc_out, out_mode
    );
endinterface

// File: rtl/mul_add_pipe.sv
// rtl/mul_add_pipe.sv - pipelined add/multiply/accumulate unit with elastic stall
// Optional build macro OPERAND_ISOLATION_EN zeroes the operands of the unit a beat does not use.
module mul_add_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int ACC_W  = 24
) (
    input  logic          clk,
    input  logic          rst,
    mul_add_pipe_if.slave bus
);
    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_MUL = 2'b01;
    localparam logic [1:0] MODE_MAC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic en;
    logic accept;

    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign accept      = bus.in_valid && en;

    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;

`ifdef OPERAND_ISOLATION_EN
    always_comb begin
        add_a = '0;
        add_b = '0;
        mul_a = '0;
        mul_b = '0;
        if (bus.mode == MODE_ADD) begin
            add_a = bus.a_in;
            add_b = bus.b_in;
        end
        if (bus.mode == MODE_MUL || bus.mode == MODE_MAC) begin
            mul_a = bus.a_in;
            mul_b = bus.b_in;
        end
    end
`else
    always_comb begin
        add_a = bus.a_in;
        add_b = bus.b_in;
        mul_a = bus.a_in;
        mul_b = bus.b_in;
    end
`endif

    logic [W:0]     sum_in;
    logic [2*W-1:0] prod_in;

    assign sum_in  = {1'b0, add_a} + {1'b0, add_b};
    assign prod_in = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    // Stage STAGES-1 is the output register; index 0 is loaded from the accepted beat.
    logic           pipe_valid [STAGES];
    logic [W:0]     pipe_s     [STAGES];
    logic [2*W-1:0] pipe_p     [STAGES];
    logic [1:0]     pipe_mode  [STAGES];

    logic           nxt_valid  [STAGES];
    logic [W:0]     nxt_s      [STAGES];
    logic [2*W-1:0] nxt_p      [STAGES];
    logic [1:0]     nxt_mode   [STAGES];

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            nxt_valid[i] = 1'b0;
            nxt_s[i]     = '0;
            nxt_p[i]     = '0;
            nxt_mode[i]  = '0;
        end
        nxt_valid[0] = accept;
        nxt_s[0]     = sum_in;
        nxt_p[0]     = prod_in;
        nxt_mode[0]  = bus.mode;
        for (int i = 1; i < STAGES; i++) begin
            nxt_valid[i] = pipe_valid[i-1];
            nxt_s[i]     = pipe_s[i-1];
            nxt_p[i]     = pipe_p[i-1];
            nxt_mode[i]  = pipe_mode[i-1];
        end
    end

    // The accumulator moves together with the beat entering the output register,
    // so consecutive MACs chain without any forwarding hazard.
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;

    always_comb begin
        acc_nxt = acc;
        if (nxt_valid[STAGES-1]) begin
            case (nxt_mode[STAGES-1])
                MODE_MAC: acc_nxt = acc + ACC_W'(nxt_p[STAGES-1]);
                MODE_CLR: acc_nxt = '0;
                default:  acc_nxt = acc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_s[i]     <= '0;
                pipe_p[i]     <= '0;
                pipe_mode[i]  <= '0;
            end
            acc <= '0;
        end else if (en) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_valid[i] <= nxt_valid[i];
                pipe_s[i]     <= nxt_s[i];
                pipe_p[i]     <= nxt_p[i];
                pipe_mode[i]  <= nxt_mode[i];
            end
            acc <= acc_nxt;
        end
    end

    assign bus.out_valid = pipe_valid[STAGES-1];
    assign bus.s_out     = pipe_s[STAGES-1];
    assign bus.p_out     = pipe_p[STAGES-1];
    assign bus.out_mode  = pipe_mode[STAGES-1];
    assign bus.acc_out   = acc;

endmodule
